// File: rtl/dram_lane_model_if.sv
// Request/response bundle for dram_lane_model: one batched multi-lane request in,
// one per-lane completion pulse out.
interface dram_lane_model_if #(
   parameter int unsigned LANES  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
) ();

   logic                     req_valid;
   logic                     req_ready;
   logic [LANES-1:0]         req_en;
   logic                     req_rdwr;
   logic [LANES*ADDR_W-1:0]  req_addr;
   logic [LANES*DATA_W-1:0]  req_data;
   logic [LANES-1:0]         resp_valid;
   logic                     resp_rdwr;
   logic [LANES*DATA_W-1:0]  resp_data;

   modport master (
      output req_valid, req_en, req_rdwr, req_addr, req_data,
      input  req_ready, resp_valid, resp_rdwr, resp_data
   );

   modport slave (
      input  req_valid, req_en, req_rdwr, req_addr, req_data,
      output req_ready, resp_valid, resp_rdwr, resp_data
   );

endinterface

// File: rtl/dram_lane_model.sv
// Fixed-latency multi-lane DRAM model. A batched request is captured in IDLE, held
// for LATENCY edges, then committed (write) or sampled (read) with a one-cycle
// per-lane response pulse.
module dram_lane_model #(
   parameter int unsigned LANES   = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned LATENCY = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   dram_lane_model_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = $clog2(LATENCY) + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_REPLY = 2'd2;

   logic [1:0]              state_q;
   logic [CNT_W-1:0]        count_q;
   logic [LANES-1:0]        cap_en_q;
   logic                    cap_rdwr_q;
   logic [LANES*ADDR_W-1:0] cap_addr_q;
   logic [LANES*DATA_W-1:0] cap_data_q;
   logic [LANES-1:0]        resp_valid_q;
   logic                    resp_rdwr_q;
   logic [LANES*DATA_W-1:0] resp_data_q;
   logic [DATA_W-1:0]       mem_q [DEPTH];

   logic accept;
   logic commit;

   // Ready depends on state only, so there is no combinational path from req_valid.
   assign bus.req_ready = (state_q == ST_IDLE);
   // An all-zero enable mask is consumed without leaving IDLE.
   assign accept        = bus.req_ready && bus.req_valid && (|bus.req_en);
   assign commit        = (state_q == ST_WAIT) && (count_q == CNT_W'(LATENCY - 1));

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdwr  = resp_rdwr_q;
   assign bus.resp_data  = resp_data_q;

   // Sequencer: capture the request, count out the latency, hold REPLY one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         cap_en_q   <= '0;
         cap_rdwr_q <= 1'b0;
         cap_addr_q <= '0;
         cap_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  cap_en_q   <= bus.req_en;
                  cap_rdwr_q <= bus.req_rdwr;
                  cap_addr_q <= bus.req_addr;
                  cap_data_q <= bus.req_data;
                  count_q    <= '0;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               count_q <= count_q + 1'b1;
               if (commit) begin
                  state_q <= ST_REPLY;
               end
            end
            ST_REPLY: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   // Response registers: pulse valid for one cycle, hold read data until the next read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q <= '0;
         resp_rdwr_q  <= 1'b0;
         resp_data_q  <= '0;
      end else if (commit) begin
         resp_valid_q <= cap_en_q;
         resp_rdwr_q  <= cap_rdwr_q;
         if (cap_rdwr_q) begin
            for (int i = 0; i < int'(LANES); i++) begin
               if (cap_en_q[i]) begin
                  resp_data_q[i*DATA_W +: DATA_W] <= mem_q[cap_addr_q[i*ADDR_W +: ADDR_W]];
               end
            end
         end
      end else if (state_q == ST_REPLY) begin
         resp_valid_q <= '0;
      end
   end

   // Storage: lanes are walked in ascending order so the highest-index lane wins a
   // same-address write collision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int w = 0; w < int'(DEPTH); w++) begin
            mem_q[w] <= '0;
         end
      end else if (commit && !cap_rdwr_q) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (cap_en_q[i]) begin
               mem_q[cap_addr_q[i*ADDR_W +: ADDR_W]] <= cap_data_q[i*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_dram_lane_model.sv
// Scoreboard bench for dram_lane_model: two instances (8x8 lanes / latency 20 and
// 2x16 lanes / latency 1), a reference memory model, and a decoupled monitor.
module tb_dram_lane_model;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dram_lane_model_if #(.LANES(8), .DATA_W(8),  .ADDR_W(6)) bus0 ();
   dram_lane_model_if #(.LANES(2), .DATA_W(16), .ADDR_W(4)) bus1 ();

   dram_lane_model #(.LANES(8), .DATA_W(8), .ADDR_W(6), .LATENCY(20)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0)
   );
   dram_lane_model #(.LANES(2), .DATA_W(16), .ADDR_W(4), .LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1)
   );

   typedef struct packed {
      logic [7:0]       en;
      logic             rd;
      logic [7:0][15:0] d;
      logic [31:0]      due;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] mdl_mem  [2][64];
   logic [15:0] mdl_last [2][8];
   int          busy[2];
   int          lat[2]   = '{20, 1};
   int          lanes[2] = '{8, 2};
   int          depth[2] = '{64, 16};
   logic [15:0] dmask[2] = '{16'h00FF, 16'hFFFF};
   int          n_cmp  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      for (int id = 0; id < 2; id++) begin
         for (int w = 0; w < 64; w++) mdl_mem[id][w] = '0;
         for (int i = 0; i < 8; i++) mdl_last[id][i] = '0;
         busy[id] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic drive(input int id, input logic v, input logic [7:0] en, input logic rd,
                        input logic [7:0][5:0] a, input logic [7:0][15:0] d);
      if (id == 0) begin
         bus0.req_valid = v;
         bus0.req_en    = en;
         bus0.req_rdwr  = rd;
         for (int i = 0; i < 8; i++) begin
            bus0.req_addr[i*6 +: 6] = a[i];
            bus0.req_data[i*8 +: 8] = d[i][7:0];
         end
      end else begin
         bus1.req_valid = v;
         bus1.req_en    = en[1:0];
         bus1.req_rdwr  = rd;
         for (int i = 0; i < 2; i++) begin
            bus1.req_addr[i*4 +: 4]   = a[i][3:0];
            bus1.req_data[i*16 +: 16] = d[i];
         end
      end
   endtask

   // Present a request, wait for ready, and record the expected response at accept.
   task automatic issue(input int id, input logic [7:0] en, input logic rd,
                        input logic [7:0][5:0] a, input logic [7:0][15:0] d,
                        input bit scramble, output int k);
      logic             rdy;
      int               waited;
      logic [7:0]       en_m;
      logic [7:0][5:0]  ra;
      logic [7:0][15:0] rdat;
      exp_t             e;
      int               idx;
      k      = -1;
      waited = 0;
      @(negedge clk);
      rdy = (id == 0) ? bus0.req_ready : bus1.req_ready;
      while (!rdy && waited < 100) begin
         if (scramble) begin
            for (int i = 0; i < 8; i++) begin
               ra[i]   = 6'($urandom);
               rdat[i] = 16'($urandom);
            end
            drive(id, 1'b1, 8'($urandom), 1'($urandom), ra, rdat);
         end
         @(negedge clk);
         waited++;
         rdy = (id == 0) ? bus0.req_ready : bus1.req_ready;
      end
      if (!rdy) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout dut%0d: req_ready stayed 0, required 1", id);
         return;
      end
      drive(id, 1'b1, en, rd, a, d);
      @(posedge clk);
      #1;
      k = cyc;
      drive(id, 1'b0, '0, 1'b0, '0, '0);
      en_m = en & 8'((1 << lanes[id]) - 1);
      if (en_m != 0) begin
         e     = '0;
         e.en  = en_m;
         e.rd  = rd;
         e.due = 32'(k + lat[id]);
         for (int i = 0; i < lanes[id]; i++) begin
            if (en_m[i]) begin
               idx = int'(a[i]) % depth[id];
               if (rd) mdl_last[id][i] = mdl_mem[id][idx];
               else    mdl_mem[id][idx] = d[i] & dmask[id];
            end
         end
         for (int i = 0; i < lanes[id]; i++) e.d[i] = mdl_last[id][i];
         if (id == 0) q0.push_back(e);
         else         q1.push_back(e);
         busy[id] = k + lat[id];
      end
   endtask

   task automatic check_resp(input int id);
      logic [7:0]       av;
      logic             ar;
      logic [7:0][15:0] ad;
      exp_t             e;
      int               qs;
      ad = '0;
      if (id == 0) begin
         av = bus0.resp_valid;
         ar = bus0.resp_rdwr;
         for (int i = 0; i < 8; i++) ad[i] = 16'(bus0.resp_data[i*8 +: 8]);
         qs = q0.size();
      end else begin
         av = 8'(bus1.resp_valid);
         ar = bus1.resp_rdwr;
         for (int i = 0; i < 2; i++) ad[i] = bus1.resp_data[i*16 +: 16];
         qs = q1.size();
      end
      if (av != 0) begin
         if (qs == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid=%0h, required none", id, av);
         end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("resp_valid dut%0d", id), 128'(av), 128'(e.en));
            chk($sformatf("resp_rdwr dut%0d", id), 128'(ar), 128'(e.rd));
            chk($sformatf("resp_data dut%0d", id), 128'(ad), 128'(e.d));
            chk($sformatf("resp_cycle dut%0d", id), 128'(cyc), 128'(e.due));
         end
      end else if (qs != 0) begin
         e = (id == 0) ? q0[0] : q1[0];
         if (cyc > int'(e.due)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_resp dut%0d: got no response, required one at cycle %0d",
                     id, e.due);
            if (id == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
         end
      end
   endtask

   // Monitor: ready against the model's busy window, then responses against the queue.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("req_ready dut0", 128'(bus0.req_ready), 128'(cyc > busy[0]));
         chk("req_ready dut1", 128'(bus1.req_ready), 128'(cyc > busy[1]));
         check_resp(0);
         check_resp(1);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q0.size() + q1.size()) != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      #1;
   endtask

   logic [7:0][5:0]  a;
   logic [7:0][15:0] d;
   int               ka;
   int               kb;

   initial begin
      reset_n = 1'b0;
      drive(0, 1'b0, '0, 1'b0, '0, '0);
      drive(1, 1'b0, '0, 1'b0, '0, '0);
      clear_model();
      repeat (3) @(negedge clk);
      chk("rst resp_valid dut0", 128'(bus0.resp_valid), 128'(0));
      chk("rst resp_rdwr dut0", 128'(bus0.resp_rdwr), 128'(0));
      chk("rst resp_data dut0", 128'(bus0.resp_data), 128'(0));
      chk("rst req_ready dut0", 128'(bus0.req_ready), 128'(1));
      chk("rst resp_valid dut1", 128'(bus1.resp_valid), 128'(0));
      chk("rst resp_data dut1", 128'(bus1.resp_data), 128'(0));
      #2;
      reset_n = 1'b1;

      // Full-width write then readback.
      for (int i = 0; i < 8; i++) begin
         a[i] = 6'(8 * i);
         d[i] = 16'(8'hA0 + i);
      end
      issue(0, 8'hFF, 1'b0, a, d, 1'b0, ka);
      issue(0, 8'hFF, 1'b1, a, d, 1'b0, ka);
      drain();
      chk("readback dut0", 128'(bus0.resp_data), 128'(64'hA7A6A5A4A3A2A1A0));

      // Partial mask: disabled lanes keep previous read data.
      for (int i = 0; i < 8; i++) a[i] = 6'(7 - i);
      issue(0, 8'h05, 1'b1, a, d, 1'b0, ka);

      // Same-address write collision: highest lane wins.
      for (int i = 0; i < 8; i++) begin
         a[i] = 6'd5;
         d[i] = 16'h0000;
      end
      d[2] = 16'h0011;
      d[3] = 16'h0022;
      issue(0, 8'h0C, 1'b0, a, d, 1'b0, ka);
      issue(0, 8'hFF, 1'b1, a, d, 1'b0, ka);
      drain();
      chk("collision read dut0", 128'(bus0.resp_data), 128'(64'h2222222222222222));

      // Back-pressure: changing junk while busy, second request lands when ready rises.
      for (int i = 0; i < 8; i++) begin
         a[i] = 6'($urandom_range(0, 15));
         d[i] = 16'($urandom);
      end
      issue(0, 8'hFF, 1'b0, a, d, 1'b0, ka);
      issue(0, 8'hFF, 1'b1, a, d, 1'b1, kb);
      chk("bp accept gap", 128'(kb - ka), 128'(22));
      drain();

      // Reset in the middle of WAIT abandons the write.
      a = '0;
      d = '0;
      a[0] = 6'd3;
      d[0] = 16'h007E;
      issue(0, 8'h01, 1'b0, a, d, 1'b0, ka);
      repeat (10) @(negedge clk);
      do_reset();
      issue(0, 8'h01, 1'b1, a, d, 1'b0, ka);
      drain();
      chk("read after reset dut0", 128'(bus0.resp_data[7:0]), 128'(0));

      // Small configuration with LATENCY = 1.
      a = '0;
      d = '0;
      a[1] = 6'd15;
      d[1] = 16'hBEEF;
      issue(1, 8'h02, 1'b0, a, d, 1'b0, ka);
      issue(1, 8'h02, 1'b1, a, d, 1'b0, ka);
      drain();
      chk("beef readback dut1", 128'(bus1.resp_data[31:16]), 128'(16'hBEEF));
      issue(1, 8'h00, 1'b1, a, d, 1'b0, ka);
      repeat (4) @(negedge clk);

      // Randomized traffic on small address ranges to provoke collisions.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 8; i++) begin
            a[i] = 6'($urandom_range(0, 7));
            d[i] = 16'($urandom);
         end
         issue(0, 8'($urandom), 1'($urandom), a, d, 1'($urandom), ka);
      end
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 8; i++) begin
            a[i] = 6'($urandom_range(0, 3));
            d[i] = 16'($urandom);
         end
         issue(1, 8'($urandom_range(0, 3)), 1'($urandom), a, d, 1'($urandom), ka);
      end
      drain();
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
